// File: rtl/status_reporter.sv
// Status line generator: turns each cmd_parser result into an ASCII line
// ("OK D=hh F=hh E=b" or "ERR") and streams it to uart_tx byte by byte.
module status_reporter #(
  parameter bit SEND_CR   = 1'b1,
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_ok,
  input  logic       cmd_err,
  input  logic [7:0] duty_cycle,
  input  logic [7:0] freq_div,
  input  logic       enable_pwm,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

  typedef struct packed {
    logic       is_err;
    logic [7:0] duty;
    logic [7:0] freq;
    logic       en;
  } req_t;

  state_t     state, state_nxt;
  req_t       cur, pend, new_snap;
  logic       pend_valid;
  logic       new_req;
  logic [4:0] idx;
  logic [4:0] last_idx;
  logic [4:0] body_len;
  logic [7:0] line_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // An ERR wins when both pulses land together; it is still one request.
  assign new_req  = cmd_ok | cmd_err;
  assign new_snap = '{is_err: cmd_err, duty: duty_cycle, freq: freq_div, en: enable_pwm};
  assign body_len = cur.is_err ? 5'd3 : 5'd16;
  assign last_idx = body_len + (SEND_CR ? 5'd1 : 5'd0);

  always_comb begin
    // NOTE: default first so every path assigns line_byte and no latch is inferred.
    line_byte = 8'h0A;
    if (idx >= body_len) begin
      if (SEND_CR && idx == body_len) line_byte = 8'h0D;
    end else if (cur.is_err) begin
      line_byte = (idx == 5'd0) ? "E" : "R";
    end else begin
      case (idx[3:0])
        4'd0:  line_byte = "O";
        4'd1:  line_byte = "K";
        4'd2:  line_byte = " ";
        4'd3:  line_byte = "D";
        4'd4:  line_byte = "=";
        4'd5:  line_byte = hex_char(cur.duty[7:4]);
        4'd6:  line_byte = hex_char(cur.duty[3:0]);
        4'd7:  line_byte = " ";
        4'd8:  line_byte = "F";
        4'd9:  line_byte = "=";
        4'd10: line_byte = hex_char(cur.freq[7:4]);
        4'd11: line_byte = hex_char(cur.freq[3:0]);
        4'd12: line_byte = " ";
        4'd13: line_byte = "E";
        4'd14: line_byte = "=";
        4'd15: line_byte = cur.en ? "1" : "0";
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (new_req || pend_valid) state_nxt = LOAD;
      LOAD:      state_nxt = START;
      // Holding off while uart_tx is still busy only matters after a reset mid-byte.
      START:     if (!tx_busy) state_nxt = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = (idx == last_idx) ? IDLE : LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    tx_start = (state == START) && !tx_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      idx        <= 5'd0;
      tx_data    <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == IDLE) begin
        // The slot is emptied as it is served, so a request arriving now refills it cleanly.
        if (pend_valid) begin
          cur        <= pend;
          pend_valid <= new_req;
          if (new_req) pend <= new_snap;
        end else if (new_req) begin
          cur <= new_snap;
        end
      end else if (new_req) begin
        pend       <= new_snap;
        pend_valid <= 1'b1;
        overrun    <= pend_valid;
      end
      if (state == LOAD) tx_data <= line_byte;
      if (state == WAIT_DONE && !tx_busy)
        idx <= (idx == last_idx) ? 5'd0 : idx + 5'd1;
    end
  end

endmodule

// File: tb/tb_status_reporter.sv
// Bench for status_reporter: two instances (CR LF / upper hex, LF / lower hex)
// share stimulus, each driving its own uart_tx model with a different busy latency.
module tb_status_reporter;

  localparam int LAT_A    = 1;
  localparam int LAT_B    = 3;
  localparam int BYTE_CYC = 4;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic         ok;
    logic         err;
    logic [7:0]   duty;
    logic [7:0]   freq;
    logic         en;
    logic [127:0] body_a;
    logic [127:0] body_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_ok, cmd_err, enable_pwm;
  logic [7:0] duty_cycle, freq_div;
  logic       tx_busy_a = 1'b0, tx_busy_b = 1'b0;
  logic       tx_start_a, tx_start_b, busy_a, busy_b, overrun_a, overrun_b;
  logic [7:0] tx_data_a, tx_data_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trig = 0;
  bit abort = 1'b0;

  byte_q_t q_a, q_b;
  int first_a = -1, first_b = -1;
  int ovr_a = 0, ovr_b = 0;
  int idle_a = 0, idle_b = 0, last_gap_a = -1, last_gap_b = -1;
  logic prev_busy_a = 1'b0, prev_busy_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  status_reporter dut_a (
    .clk(clk), .rst(rst), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
    .duty_cycle(duty_cycle), .freq_div(freq_div), .enable_pwm(enable_pwm),
    .tx_busy(tx_busy_a), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  status_reporter #(.SEND_CR(1'b0), .HEX_UPPER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
    .duty_cycle(duty_cycle), .freq_div(freq_div), .enable_pwm(enable_pwm),
    .tx_busy(tx_busy_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  // uart_tx models: busy rises LAT cycles after tx_start, stays high BYTE_CYC cycles.
  int dly_a = 0, hold_a = 0, dly_b = 0, hold_b = 0;
  always @(posedge clk) begin
    if (tx_start_a) begin
      if (LAT_A == 1) begin tx_busy_a <= 1'b1; hold_a <= BYTE_CYC; end
      else dly_a <= LAT_A - 1;
    end else if (dly_a > 0) begin
      dly_a <= dly_a - 1;
      if (dly_a == 1) begin tx_busy_a <= 1'b1; hold_a <= BYTE_CYC; end
    end else if (hold_a > 0) begin
      hold_a <= hold_a - 1;
      if (hold_a == 1) tx_busy_a <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (tx_start_b) begin
      if (LAT_B == 1) begin tx_busy_b <= 1'b1; hold_b <= BYTE_CYC; end
      else dly_b <= LAT_B - 1;
    end else if (dly_b > 0) begin
      dly_b <= dly_b - 1;
      if (dly_b == 1) begin tx_busy_b <= 1'b1; hold_b <= BYTE_CYC; end
    end else if (hold_b > 0) begin
      hold_b <= hold_b - 1;
      if (hold_b == 1) tx_busy_b <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string show(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      if (s[i] < 8'd32) r = $sformatf("%s<%02h>", r, s[i]);
      else              r = $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, show(act), show(exp));
    end
  endtask

  function automatic string body_str(input logic [127:0] b);
    string s = "";
    for (int i = 15; i >= 0; i--)
      if (b[i*8 +: 8] != 8'h00) s = $sformatf("%s%c", s, b[i*8 +: 8]);
    return s;
  endfunction

  function automatic string q_to_str(input byte_q_t q);
    string s = "";
    foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
    return s;
  endfunction

  // Monitors: capture bytes, timing of first start, overrun pulses and idle gaps.
  always @(negedge clk) begin
    if (tx_start_a) begin
      q_a.push_back(tx_data_a);
      if (first_a < 0) first_a = cyc;
      check("a_start_while_busy", {31'd0, tx_busy_a}, 32'd0);
    end
    if (overrun_a) ovr_a++;
    if (busy_a) begin
      if (!prev_busy_a) last_gap_a = idle_a;
      idle_a = 0;
    end else begin
      if (prev_busy_a && !abort) check("a_busy_fall", {31'd0, tx_busy_a}, 32'd0);
      idle_a++;
    end
    prev_busy_a = busy_a;
  end

  always @(negedge clk) begin
    if (tx_start_b) begin
      q_b.push_back(tx_data_b);
      if (first_b < 0) first_b = cyc;
      check("b_start_while_busy", {31'd0, tx_busy_b}, 32'd0);
    end
    if (overrun_b) ovr_b++;
    if (busy_b) begin
      if (!prev_busy_b) last_gap_b = idle_b;
      idle_b = 0;
    end else begin
      if (prev_busy_b && !abort) check("b_busy_fall", {31'd0, tx_busy_b}, 32'd0);
      idle_b++;
    end
    prev_busy_b = busy_b;
  end

  task automatic clear_mon();
    q_a.delete(); q_b.delete();
    first_a = -1; first_b = -1;
    ovr_a = 0; ovr_b = 0;
    last_gap_a = -1; last_gap_b = -1;
  endtask

  task automatic pulse_cmd(input logic ok, input logic err, input logic [7:0] d,
                           input logic [7:0] f, input logic e);
    duty_cycle = d; freq_div = f; enable_pwm = e;
    cmd_ok = ok; cmd_err = err;
    trig = cyc;
    @(negedge clk);
    cmd_ok = 1'b0; cmd_err = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int streak = 0;
    int n = 0;
    while (streak < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy_a && !busy_b && !tx_busy_a && !tx_busy_b) streak++;
      else streak = 0;
    end
    check({name, "_done_in_time"}, {31'd0, streak >= 4}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_tx_start"}, {31'd0, tx_start_a}, 32'd0);
    check({tag, "_a_tx_data"},  {24'd0, tx_data_a},  32'd0);
    check({tag, "_a_busy"},     {31'd0, busy_a},     32'd0);
    check({tag, "_a_overrun"},  {31'd0, overrun_a},  32'd0);
    check({tag, "_b_tx_start"}, {31'd0, tx_start_b}, 32'd0);
    check({tag, "_b_tx_data"},  {24'd0, tx_data_b},  32'd0);
    check({tag, "_b_busy"},     {31'd0, busy_b},     32'd0);
    check({tag, "_b_overrun"},  {31'd0, overrun_b},  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  vec_t vecs[6];
  int   n_a, n_b;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h3C, 8'h05, 1'b1, 128'("OK D=3C F=05 E=1"), 128'("OK D=3c F=05 E=1")};
    vecs[1] = '{1'b0, 1'b1, 8'h3C, 8'h05, 1'b1, 128'("ERR"),              128'("ERR")};
    vecs[2] = '{1'b1, 1'b1, 8'hAB, 8'h05, 1'b1, 128'("ERR"),              128'("ERR")};
    vecs[3] = '{1'b1, 1'b0, 8'hAB, 8'hF0, 1'b0, 128'("OK D=AB F=F0 E=0"), 128'("OK D=ab F=f0 E=0")};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h9F, 1'b1, 128'("OK D=00 F=9F E=1"), 128'("OK D=00 F=9f E=1")};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h5A, 1'b0, 128'("OK D=FF F=5A E=0"), 128'("OK D=ff F=5a E=0")};

    rst = 1'b1; cmd_ok = 1'b0; cmd_err = 1'b0;
    duty_cycle = 8'h00; freq_div = 8'h00; enable_pwm = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      pulse_cmd(vecs[i].ok, vecs[i].err, vecs[i].duty, vecs[i].freq, vecs[i].en);
      wait_done($sformatf("v%0d", i), 2000);
      check_str($sformatf("v%0d_line_a", i), q_to_str(q_a), {body_str(vecs[i].body_a), "\r\n"});
      check_str($sformatf("v%0d_line_b", i), q_to_str(q_b), {body_str(vecs[i].body_b), "\n"});
      check($sformatf("v%0d_first_start_a", i), first_a - trig, 32'd2);
      check($sformatf("v%0d_first_start_b", i), first_b - trig, 32'd2);
      check($sformatf("v%0d_overrun_a", i), ovr_a, 32'd0);
      check($sformatf("v%0d_overrun_b", i), ovr_b, 32'd0);
    end

    // Snapshot: duty changes the cycle after the trigger.
    clear_mon();
    pulse_cmd(1'b1, 1'b0, 8'h3C, 8'h05, 1'b1);
    duty_cycle = 8'hFF;
    wait_done("snap", 2000);
    check_str("snap_line_a", q_to_str(q_a), "OK D=3C F=05 E=1\r\n");
    check_str("snap_line_b", q_to_str(q_b), "OK D=3c F=05 E=1\n");

    // Pending slot: second request overwrites the first queued one.
    clear_mon();
    pulse_cmd(1'b1, 1'b0, 8'h3C, 8'h05, 1'b1);
    repeat (10) @(negedge clk);
    pulse_cmd(1'b1, 1'b0, 8'h10, 8'h22, 1'b0);
    repeat (5) @(negedge clk);
    pulse_cmd(1'b0, 1'b1, 8'h10, 8'h22, 1'b0);
    wait_done("pend", 4000);
    check_str("pend_lines_a", q_to_str(q_a), "OK D=3C F=05 E=1\r\nERR\r\n");
    check_str("pend_lines_b", q_to_str(q_b), "OK D=3c F=05 E=1\nERR\n");
    check("pend_overrun_a", ovr_a, 32'd1);
    check("pend_overrun_b", ovr_b, 32'd1);
    check("pend_gap_a", last_gap_a, 32'd1);
    check("pend_gap_b", last_gap_b, 32'd1);

    // Reset in the middle of a line.
    clear_mon();
    pulse_cmd(1'b1, 1'b0, 8'h3C, 8'h05, 1'b1);
    begin
      int n = 0;
      while (q_a.size() < 7 && n < 1000) begin @(negedge clk); n++; end
      check("abort_reached_byte7", {31'd0, q_a.size() >= 7}, 32'd1);
    end
    abort = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    n_a = q_a.size();
    n_b = q_b.size();
    repeat (60) @(negedge clk);
    check("abort_no_more_bytes_a", q_a.size(), n_a);
    check("abort_no_more_bytes_b", q_b.size(), n_b);
    check("abort_idle_a", {31'd0, busy_a}, 32'd0);
    check("abort_idle_b", {31'd0, busy_b}, 32'd0);
    abort = 1'b0;

    // A fresh request after the abort runs normally.
    clear_mon();
    pulse_cmd(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    wait_done("post", 2000);
    check_str("post_line_a", q_to_str(q_a), "ERR\r\n");
    check_str("post_line_b", q_to_str(q_b), "ERR\n");
    check("post_first_start_a", first_a - trig, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/status_reporter.md
Name: status_reporter

Overview:
- Response stage between cmd_parser and uart_tx.
- On each parser result, sends one ASCII status line to uart_tx, one byte at a time, using the uart_tx tx_start/tx_busy handshake.
- Replaces the raw byte echo as the driver of uart_tx; no other change to the TX path.

Parameters:
- SEND_CR, 1, 1: lines end in CR LF; 0: lines end in LF only.
- HEX_UPPER, 1, 1: hex digits A-F; 0: a-f.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cmd_ok  in  1  one-cycle pulse: parser accepted a command
- cmd_err  in  1  one-cycle pulse: parser rejected a command
- duty_cycle  in  8  current duty from parser
- freq_div  in  8  current divider from parser
- enable_pwm  in  1  current enable from parser
- tx_busy  in  1  uart_tx busy
- tx_start  out  1  one-cycle pulse to uart_tx
- tx_data  out  8  byte to uart_tx; valid and stable while tx_start=1
- busy  out  1  line transmission in progress
- overrun  out  1  one-cycle pulse: pending request overwritten

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - tx_start=0, tx_data=8'h00, busy=0, overrun=0.
  - FSM=IDLE; pending slot empty; byte index=0.
- Reset mid-line aborts the line immediately and discards any pending request. A byte already accepted by uart_tx still completes on the wire.

Line formats:
- OK line: "OK D=hh F=hh E=b" then terminator.
  - hh: two hex digits of the snapshot value, MSB nibble first.
  - b: '0' or '1'.
  - Length 18 bytes with SEND_CR=1, 17 with SEND_CR=0.
- ERR line: "ERR" then terminator. Length 5 or 4 bytes.
- Terminator: 8'h0D 8'h0A, or 8'h0A only.

Request capture:
- Sampled every cycle.
- cmd_err and cmd_ok in the same cycle counts as a single ERR request.
- The request type and snapshot {duty_cycle, freq_div, enable_pwm} are captured on the trigger cycle. Later input changes do not affect the line being sent.
- IDLE with no pending request: the request starts immediately.
- Otherwise it goes into the one-deep pending slot.
  - If the slot is already full, it is overwritten (type and snapshot).
  - overrun pulses for 1 cycle on the overwrite.

FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE.
- IDLE: busy=0.
  - Request present (new or pending) -> LOAD.
  - If taken from the slot, the slot is cleared in the same cycle.
- LOAD: select the byte for the current index; register it into tx_data -> START.
- START:
  - tx_start=1 for exactly 1 cycle -> WAIT_ACK.
  - First tx_start occurs 2 cycles after the trigger cycle.
- WAIT_ACK: hold until tx_busy=1 -> WAIT_DONE. Tolerates any uart_tx busy latency of 1 cycle or more.
- WAIT_DONE: hold until tx_busy=0.
  - Last byte -> IDLE, index=0.
  - Otherwise index+1 -> LOAD.
- busy=1 in every state except IDLE.
- A pending request is served in the IDLE cycle after line completion, giving one idle cycle between lines.

Encoding and widths:
- Nibble to ASCII: 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10), or 8'h61+(n-10) if HEX_UPPER=0.
- Index counter is 5 bits. Last-index compare uses line type and SEND_CR.
- tx_start is never asserted while tx_busy=1.

Test Plan:
- Basic OK: rst, then duty=8'h3C, freq=8'h05, en=1, pulse cmd_ok -> exactly 18 tx_start pulses, bytes "OK D=3C F=05 E=1\r\n". First tx_start on trigger+2 cycles; busy falls after the last tx_busy falls.
- ERR and SEND_CR: SEND_CR=0, pulse cmd_err -> bytes 45 52 52 0A, then busy=0. SEND_CR=1 -> 45 52 52 0D 0A.
- Simultaneous/lowercase: HEX_UPPER=0, duty=8'hAB, cmd_ok and cmd_err in the same cycle -> a single "ERR" line only. Then cmd_ok with duty=8'hAB, freq=8'hF0, en=0 -> "OK D=ab F=f0 E=0".
- Pending and overrun:
  - During an OK line, pulse cmd_ok (duty=8'h10), then cmd_err.
  - Second pulse -> overrun high 1 cycle.
  - After the first line: one idle cycle, then "ERR" line. No "D=10" line.
- Snapshot stability: change duty from 8'h3C to 8'hFF one cycle after cmd_ok -> line still reports D=3C.
- Handshake/reset:
  - uart_tx model with busy latency 3 cycles -> no tx_start while tx_busy=1; all bytes delivered.
  - Assert rst at byte 7 -> outputs return to reset values immediately; no further tx_start until a new trigger.
